gmm_stream_frame_ctrl: RTL

- Parametrised streaming front/back-end for the GMM background-subtraction core.
- Accepts RGB pixel beats with sop/eop and converts them to grey.
- Sequences frames (first-frame learning vs steady state) and generates model-memory read/write addresses.
- Issues pixels to a fixed-latency GMM core, carries sop/eop tags alongside, buffers results in a credit-protected output FIFO, and drives an Avalon-ST-style source with full backpressure.

---
 rtl/gmm_stream_pkg.sv | 19 +
 rtl/gmm_stream_fifo.sv | 45 ++++
 rtl/gmm_stream_frame_ctrl.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/gmm_stream_pkg.sv
// Shared types and constants for the GMM stream front/back-end.
package gmm_stream_pkg;

  typedef enum logic [1:0] {WAIT_SOP, FIRST, RUN} state_t;

  // Tag address is carried at a fixed width; the top keeps only ADDR_W bits.
  localparam int TAG_ADDR_W = 32;

  typedef struct packed {
    logic [TAG_ADDR_W-1:0] addr;
    logic                  sop;
    logic                  eop;
  } tag_t;

  localparam int LUMA_R = 77;
  localparam int LUMA_G = 150;
  localparam int LUMA_B = 29;

endpackage

// File: rtl/gmm_stream_fifo.sv
// Show-ahead synchronous FIFO; rdata always presents the head entry.
module gmm_stream_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty,
  output logic                     full
);
  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             do_push, do_pop;

  // A pop frees the head slot in the same cycle, so push at full is legal with it.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign empty   = (count == '0);
  assign full    = (count == (AW+1)'(DEPTH));
  assign rdata   = mem[rp];

  always_ff @(posedge clk) begin
    if (do_push) mem[wp] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop)  rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

endmodule

// File: rtl/gmm_stream_frame_ctrl.sv
// Frame sequencer, grey conversion, core tag pipeline and credit-protected output FIFO.
// Build option GMM_LUMA_WEIGHT_EN selects the 2-stage 77/150/29 luma weighting.
module gmm_stream_frame_ctrl
  import gmm_stream_pkg::*;
#(
  parameter int PIX_W        = 8,
  parameter int RES_W        = 8,
  parameter int FRAME_PIXELS = 76800,
  parameter int ADDR_W       = 18,
  parameter int CORE_LAT     = 4,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [3*PIX_W-1:0]  data_in,
  input  logic                valid_in,
  output logic                ready_out,
  input  logic                sop_in,
  input  logic                eop_in,
  output logic                core_valid,
  output logic [PIX_W-1:0]    core_grey,
  output logic [ADDR_W-1:0]   core_raddr,
  output logic                core_first_frame,
  output logic [ADDR_W-1:0]   core_waddr,
  output logic                core_we,
  input  logic                core_res_valid,
  input  logic [RES_W-1:0]    core_res,
  output logic [RES_W-1:0]    data_out,
  output logic                valid_out,
  input  logic                ready_in,
  output logic                sop_out,
  output logic                eop_out,
  output logic                frame_err,
  output logic [15:0]         frame_cnt
);
  localparam int CW = $clog2(FIFO_DEPTH) + 1;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(FRAME_PIXELS - 1);

  state_t            state, state_n;
  logic [ADDR_W-1:0] pix_idx, idx_n, cur_idx;
  logic              learn, acc, issue, err, done, pop;
  logic [CW-1:0]     used, used_n;
  logic [PIX_W-1:0]  red, grn, blu;

  assign {blu, grn, red} = data_in;
  assign acc = valid_in && ready_out;

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= WAIT_SOP;
      pix_idx   <= '0;
      learn     <= 1'b1;
      frame_cnt <= '0;
      frame_err <= 1'b0;
      used      <= '0;
      ready_out <= 1'b0;
    end else begin
      state     <= state_n;
      pix_idx   <= idx_n;
      frame_err <= err;
      used      <= used_n;
      // A sop beat in WAIT_SOP also needs a credit, so idle is not exempt.
      ready_out <= (used_n < CW'(FIFO_DEPTH));
      if (done) begin
        learn     <= 1'b0;
        frame_cnt <= frame_cnt + 16'd1;
      end
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = pix_idx;
    err     = 1'b0;
    done    = 1'b0;
    if (issue) begin
      err     = (state != WAIT_SOP) && sop_in;
      state_n = learn ? FIRST : RUN;
      idx_n   = cur_idx + ADDR_W'(1);
      if (eop_in || cur_idx == LAST) begin
        state_n = WAIT_SOP;
        idx_n   = '0;
        if (eop_in && cur_idx == LAST) done = 1'b1;
        else                           err  = 1'b1;
      end
    end
  end

  always_comb begin
    issue   = acc && ((state != WAIT_SOP) || sop_in);
    cur_idx = sop_in ? '0 : pix_idx;
  end

  assign used_n = used + CW'(issue) - CW'(pop);

  logic              iss_vld, iss_sop, iss_eop, iss_learn;
  logic [ADDR_W-1:0] iss_idx;
  logic [PIX_W-1:0]  iss_grey;

`ifdef GMM_LUMA_WEIGHT_EN
  localparam int PW = PIX_W + 8;
  logic              s1_vld, s1_sop, s1_eop, s1_learn;
  logic [ADDR_W-1:0] s1_idx;
  logic [PW-1:0]     s1_r, s1_g, s1_b, lsum;

  always_ff @(posedge clk) begin
    if (rst) begin
      {s1_vld, s1_sop, s1_eop, s1_learn} <= '0;
      s1_idx <= '0;
      s1_r   <= '0;
      s1_g   <= '0;
      s1_b   <= '0;
    end else begin
      s1_vld   <= issue;
      s1_sop   <= sop_in;
      s1_eop   <= eop_in;
      s1_learn <= learn;
      s1_idx   <= cur_idx;
      s1_r     <= PW'(LUMA_R) * PW'(red);
      s1_g     <= PW'(LUMA_G) * PW'(grn);
      s1_b     <= PW'(LUMA_B) * PW'(blu);
    end
  end

  // Weights sum to 256, so the sum of products never exceeds PIX_W+8 bits.
  assign lsum      = s1_r + s1_g + s1_b;
  assign iss_grey  = PIX_W'(lsum >> 8);
  assign iss_vld   = s1_vld;
  assign iss_sop   = s1_sop;
  assign iss_eop   = s1_eop;
  assign iss_learn = s1_learn;
  assign iss_idx   = s1_idx;
`else
  logic [PIX_W+1:0] gsum;
  assign gsum      = {2'b0, red} + {1'b0, grn, 1'b0} + {2'b0, blu};
  assign iss_grey  = PIX_W'(gsum >> 2);
  assign iss_vld   = issue;
  assign iss_sop   = sop_in;
  assign iss_eop   = eop_in;
  assign iss_learn = learn;
  assign iss_idx   = cur_idx;
`endif

  logic core_sop, core_eop;

  always_ff @(posedge clk) begin
    if (rst) begin
      {core_valid, core_first_frame, core_sop, core_eop} <= '0;
      core_grey  <= '0;
      core_raddr <= '0;
    end else begin
      core_valid       <= iss_vld;
      core_first_frame <= iss_vld & iss_learn;
      core_sop         <= iss_vld & iss_sop;
      core_eop         <= iss_vld & iss_eop;
      core_grey        <= iss_grey;
      core_raddr       <= iss_idx;
    end
  end

  tag_t                tag_pipe [CORE_LAT];
  logic [CORE_LAT-1:0] vld_pipe;
  tag_t                tail;
  logic                unused_tag_bits;

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_pipe <= '0;
      for (int i = 0; i < CORE_LAT; i++) tag_pipe[i] <= '0;
    end else begin
      vld_pipe[0] <= core_valid;
      tag_pipe[0] <= '{addr: TAG_ADDR_W'(core_raddr), sop: core_sop, eop: core_eop};
      for (int i = 1; i < CORE_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        tag_pipe[i] <= tag_pipe[i-1];
      end
    end
  end

  assign tail            = tag_pipe[CORE_LAT-1];
  assign core_waddr      = tail.addr[ADDR_W-1:0];
  assign core_we         = core_res_valid;
  assign unused_tag_bits = ^tail.addr;

  logic [RES_W+1:0] head;
  logic [CW-1:0]    fifo_cnt;
  logic             empty, full;

  gmm_stream_fifo #(.WIDTH(RES_W + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (core_res_valid),
    .wdata ({tail.sop, tail.eop, core_res}),
    .pop   (pop),
    .rdata (head),
    .count (fifo_cnt),
    .empty (empty),
    .full  (full)
  );

  assign valid_out = ~empty;
  assign pop       = valid_out && ready_in;
  assign data_out  = empty ? '0 : head[RES_W-1:0];
  assign sop_out   = ~empty & head[RES_W+1];
  assign eop_out   = ~empty & head[RES_W];

  a_res_has_tag: assert property (@(posedge clk) disable iff (rst)
    core_res_valid |-> vld_pipe[CORE_LAT-1]);
  a_no_overflow: assert property (@(posedge clk) disable iff (rst)
    core_res_valid |-> (!full || pop));
  a_credit_cover: assert property (@(posedge clk) disable iff (rst)
    fifo_cnt <= used);

endmodule
